serial_sub: RTL and testbench

- Bit-serial subtractor: computes diff = a - b - bin, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Complement to the team's ripple adders. Trades WIDTH cycles of latency for one-cell area.
- Sits behind a start/done handshake so a controller FSM can issue back-to-back operations.

---
 rtl/serial_sub.sv | 81 ++++++++
 tb/tb_serial_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a-b-bin subtractor with start/done handshake; define SERIAL_SUB_SIGNED_EN to add the ovf output.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0] cnt;
    logic br, d, br_nx, load, last;
`ifdef SERIAL_SUB_SIGNED_EN
    logic am, bm;
`endif
    always_comb begin
        d        = ra[0] ^ rb[0] ^ br;
        br_nx    = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        load     = start && state != BUSY;
        last     = state == BUSY && cnt == CW'(WIDTH - 1);
        state_nx = load ? BUSY : last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra   <= '0;
            rb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            am   <= 1'b0;
            bm   <= 1'b0;
            ovf  <= 1'b0;
`endif
        end else if (load) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
            am  <= a[WIDTH-1];
            bm  <= b[WIDTH-1];
`endif
        end else if (state == BUSY) begin
            ra   <= ra >> 1;
            rb   <= rb >> 1;
            br   <= br_nx;
            cnt  <= cnt + CW'(1);
            diff <= {d, diff[WIDTH-1:1]};
            if (last) begin
                bout <= br_nx;
`ifdef SERIAL_SUB_SIGNED_EN
                // d is the final diff MSB, shifted in on this same edge
                ovf  <= (am != bm) && (d != am);
`endif
            end
        end
    end
    assign busy = state == BUSY;
    assign done = state == DONE;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub against an integer-arithmetic reference.
module tb_serial_sub;
    localparam int W = 4;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_SIGNED_EN
    logic ovf;
`endif
    int errs = 0, checks = 0;
    typedef struct {
        logic [W-1:0] d;
        logic bo;
        logic ov;
    } exp_t;
    exp_t q[$];
    exp_t me;
    always #5 clk = ~clk;
    serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_SIGNED_EN
        , .ovf(ovf)
`endif
    );
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic c);
        exp_t e;
        int u, s;
        u = int'(x) - int'(y) - int'(c);
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        e.d  = W'(u);
        e.bo = u < 0;
        e.ov = s < -(1 << (W - 1)) || s >= (1 << (W - 1));
        return e;
    endfunction
    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                me = q.pop_front();
                chk("diff", int'(diff), int'(me.d));
                chk("bout", int'(bout), int'(me.bo));
                chk("busy_in_done", int'(busy), 0);
`ifdef SERIAL_SUB_SIGNED_EN
                chk("ovf", int'(ovf), int'(me.ov));
`endif
            end
        end
    end
    task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic c);
        a = x;
        b = y;
        bin = c;
        start = 1'b1;
        q.push_back(model(x, y, c));
    endtask
    task automatic wait_done(output int cyc, output int nb);
        bit seen = 0;
        nb = int'(busy);
        cyc = 0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1;
            else nb += int'(busy);
        end
        if (!seen) begin
            checks++;
            errs++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done after %0d", cyc, W);
        end
    endtask
    task automatic op(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int cyc, nb;
        issue(x, y, c);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, nb);
        chk("latency", cyc, W);
        chk("busy_cycles", nb, W);
    endtask
    task automatic gap(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        int cyc, nb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        reset = 1'b0;
        gap(1);
        op(4'b0110, 4'b0011, 1'b0);
        gap(1);
        op(4'b0010, 4'b0101, 1'b0);
        gap(1);
        op(4'b1000, 4'b0000, 1'b1);
        gap(2);
        // start stays high: new operands during BUSY are ignored, then taken in DONE
        issue(4'b0110, 4'b0011, 1'b0);
        @(posedge clk);
        #1;
        issue(4'b1111, 4'b0001, 1'b0);
        wait_done(cyc, nb);
        chk("held_latency", cyc, W);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, nb);
        chk("second_latency", cyc, W);
        gap(2);
        a = 4'b1010;
        b = 4'b0101;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        gap(2);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_bout", int'(bout), 0);
        gap(2);
        reset = 1'b0;
        gap(1);
        op(4'b1010, 4'b0101, 1'b0);
        for (int i = 0; i < 512; i++) begin
            gap($urandom_range(0, 2));
            op(W'(i), W'(i >> 4), 1'(i >> 8));
        end
        gap(1);
        issue(W'($urandom), W'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        for (int k = 1; k < 40; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(cyc, nb);
            chk("b2b_latency", cyc, W);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(cyc, nb);
        chk("b2b_last_latency", cyc, W);
        gap(3);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
